// File: rtl/elevator_scheduler.sv
// LOOK-order request scheduler and motion sequencer for the elevator car.
// Define ELEVATOR_HOME_RETURN_EN to park the car at HOME_FLOOR after IDLE_TICKS idle step ticks.
module elevator_scheduler #(
    parameter int NUM_FLOORS = 8,
    parameter int DOOR_TICKS = 2
`ifdef ELEVATOR_HOME_RETURN_EN
    ,
    parameter int HOME_FLOOR = 1,
    parameter int IDLE_TICKS = 4
`endif
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  step_tick,
    input  logic                  call_valid,
    input  logic [3:0]            call_floor,
    output logic                  call_ack,
    output logic [NUM_FLOORS-1:0] req_pending,
    output logic [3:0]            floor_now,
    output logic                  move_dir,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrive,
    output logic                  busy
);

    localparam int DT = (DOOR_TICKS < 1) ? 1 : DOOR_TICKS;
    localparam int DW = $clog2(DT + 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t                r_state;
    logic [3:0]            r_floor;
    logic                  r_dir;
    logic [NUM_FLOORS-1:0] r_pend;
    logic [DW-1:0]         r_dwell;
    logic                  r_ack;
    logic                  r_arrive;

    function automatic logic [NUM_FLOORS-1:0] f_onehot(input logic [3:0] fl);
        f_onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (int'(fl) == i + 1) f_onehot[i] = 1'b1;
    endfunction

    logic                  w_legal;
    logic                  w_call_here;
    logic                  w_here_pend;
    logic                  w_ahead;
    logic                  w_behind;
    logic                  w_step_hit;
    logic [3:0]            w_step_floor;
    logic [NUM_FLOORS-1:0] w_above;
    logic [NUM_FLOORS-1:0] w_below;
    logic [NUM_FLOORS-1:0] w_here_mask;
    logic [NUM_FLOORS-1:0] w_step_mask;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_home_mask;

    always_comb begin
        w_above = '0;
        w_below = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_above[i] = r_pend[i] && (i + 1 > int'(r_floor));
            w_below[i] = r_pend[i] && (i + 1 < int'(r_floor));
        end
    end

    assign w_legal      = call_valid && (call_floor != 4'd0) && (int'(call_floor) <= NUM_FLOORS);
    assign w_call_here  = w_legal && (call_floor == r_floor);
    assign w_here_mask  = f_onehot(r_floor);
    assign w_here_pend  = |(r_pend & w_here_mask);
    assign w_ahead      = r_dir ? |w_above : |w_below;
    assign w_behind     = r_dir ? |w_below : |w_above;
    assign w_step_floor = r_dir ? r_floor + 4'd1 : r_floor - 4'd1;
    assign w_step_mask  = f_onehot(w_step_floor);
    // A call landing on the floor being reached this tick is served by that stop.
    assign w_step_hit   = |((r_pend | w_set) & w_step_mask);
    assign w_set        = (w_legal && !(w_call_here && r_state != S_MOVE)) ? f_onehot(call_floor) : '0;

    always_comb begin
        w_clr = '0;
        if (r_state == S_MOVE && step_tick && w_ahead && w_step_hit)
            w_clr = w_step_mask;
        else if (r_state == S_IDLE && w_here_pend)
            w_clr = w_here_mask;
    end

`ifdef ELEVATOR_HOME_RETURN_EN
    localparam int IT = (IDLE_TICKS < 1) ? 1 : IDLE_TICKS;
    localparam int IW = $clog2(IT + 1);

    logic [IW-1:0] r_idle_cnt;
    logic          w_idle_run;

    assign w_idle_run  = (r_state == S_IDLE) && (r_floor != 4'(HOME_FLOOR)) && !call_valid && (r_pend == '0);
    assign w_home_mask = (w_idle_run && step_tick && r_idle_cnt == IW'(IT - 1)) ? f_onehot(4'(HOME_FLOOR)) : '0;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || !w_idle_run)
            r_idle_cnt <= '0;
        else if (step_tick)
            r_idle_cnt <= (r_idle_cnt == IW'(IT - 1)) ? '0 : r_idle_cnt + 1'b1;
    end
`else
    assign w_home_mask = '0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state  <= S_IDLE;
            r_floor  <= 4'd1;
            r_dir    <= 1'b1;
            r_pend   <= '0;
            r_dwell  <= '0;
            r_ack    <= 1'b0;
            r_arrive <= 1'b0;
        end else begin
            r_ack    <= w_legal;
            r_arrive <= 1'b0;
            r_pend   <= (r_pend | w_set | w_home_mask) & ~w_clr;
            case (r_state)
                S_IDLE: begin
                    if (w_call_here || w_here_pend) begin
                        r_state  <= S_DOOR;
                        r_dwell  <= DW'(DT);
                        r_arrive <= 1'b1;
                    end else if (|r_pend) begin
                        r_state <= S_MOVE;
                        if (!w_ahead) r_dir <= ~r_dir;
                    end
                end
                S_MOVE: begin
                    if (step_tick) begin
                        if (!w_ahead) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_floor <= w_step_floor;
                            if (w_step_floor == 4'(NUM_FLOORS))
                                r_dir <= 1'b0;
                            else if (w_step_floor == 4'd1)
                                r_dir <= 1'b1;
                            if (w_step_hit) begin
                                r_state  <= S_DOOR;
                                r_dwell  <= DW'(DT);
                                r_arrive <= 1'b1;
                            end
                        end
                    end
                end
                S_DOOR: begin
                    if (w_call_here) begin
                        r_dwell <= DW'(DT);
                    end else if (step_tick) begin
                        if (r_dwell <= DW'(1)) begin
                            r_dwell <= '0;
                            if (w_ahead) begin
                                r_state <= S_MOVE;
                            end else if (w_behind) begin
                                r_state <= S_MOVE;
                                r_dir   <= ~r_dir;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_dwell <= r_dwell - 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign call_ack    = r_ack;
    assign req_pending = r_pend;
    assign floor_now   = r_floor;
    assign move_dir    = r_dir;
    assign moving      = (r_state == S_MOVE);
    assign door_open   = (r_state == S_DOOR);
    assign arrive      = r_arrive;
    assign busy        = (r_state != S_IDLE) || (|r_pend);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler; arrival floors are scoreboarded against
// an expected queue filled as calls are issued.
module tb_elevator_scheduler;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       step_tick = 1'b0;
    logic       call_valid = 1'b0;
    logic [3:0] call_floor = 4'd0;
    logic       call_ack;
    logic [7:0] req_pending;
    logic [3:0] floor_now;
    logic       move_dir;
    logic       moving;
    logic       door_open;
    logic       arrive;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int arr_q[$];

    always #5 sys_clk = ~sys_clk;

    elevator_scheduler dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .step_tick   (step_tick),
        .call_valid  (call_valid),
        .call_floor  (call_floor),
        .call_ack    (call_ack),
        .req_pending (req_pending),
        .floor_now   (floor_now),
        .move_dir    (move_dir),
        .moving      (moving),
        .door_open   (door_open),
        .arrive      (arrive),
        .busy        (busy)
    );

    always @(negedge sys_clk)
        if (arrive === 1'b1) arr_q.push_back(int'(floor_now));

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic tick();
        @(negedge sys_clk) step_tick = 1'b1;
        @(negedge sys_clk) step_tick = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic call(input int f);
        @(negedge sys_clk);
        call_valid = 1'b1;
        call_floor = 4'(f);
        @(negedge sys_clk) call_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk) sys_rst_n = 1'b0;
        @(negedge sys_clk) sys_rst_n = 1'b1;
    endtask

    task automatic cmp_arr(input string tag);
        int e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (arr_q.size() == 0) chk({tag, "_missing"}, 0, e);
            else                   chk(tag, arr_q.pop_front(), e);
        end
        chk({tag, "_extra"}, arr_q.size(), 0);
    endtask

    initial begin
        cyc(2);
        chk("rst_floor", floor_now, 1);
        chk("rst_dir", move_dir, 1);
        chk("rst_pend", req_pending, 0);
        chk("rst_ack", call_ack, 0);
        chk("rst_arrive", arrive, 0);
        chk("rst_door", door_open, 0);
        chk("rst_moving", moving, 0);
        chk("rst_busy", busy, 0);
        sys_rst_n = 1'b1;
        cyc(1);

        // single call from floor 1 to 5
        call(5);
        exp_q.push_back(5);
        chk("t1_ack", call_ack, 1);
        chk("t1_pend", req_pending, 8'h10);
        cyc(1);
        chk("t1_ack_pulse", call_ack, 0);
        chk("t1_moving", moving, 1);
        chk("t1_dir", move_dir, 1);
        for (int f = 2; f <= 5; f++) begin
            tick();
            chk("t1_floor", floor_now, f);
        end
        chk("t1_door", door_open, 1);
        chk("t1_stopped", moving, 0);
        chk("t1_pend_clr", req_pending, 0);
        tick();
        chk("t1_dwell1", door_open, 1);
        tick();
        chk("t1_dwell2", door_open, 0);
        chk("t1_busy", busy, 0);
        chk("t1_floor_end", floor_now, 5);
        cmp_arr("t1_arrive");

        // LOOK reversal: moving up at 3 with calls 6 and 2
        do_reset();
        call(6);
        exp_q.push_back(6);
        tick();
        tick();
        chk("t2_at3", floor_now, 3);
        call(2);
        exp_q.push_back(2);
        chk("t2_pend", req_pending, 8'h22);
        for (int f = 4; f <= 6; f++) begin
            tick();
            chk("t2_up_floor", floor_now, f);
        end
        chk("t2_door6", door_open, 1);
        tick();
        chk("t2_dwell", door_open, 1);
        tick();
        chk("t2_rev_moving", moving, 1);
        chk("t2_rev_dir", move_dir, 0);
        chk("t2_rev_floor", floor_now, 6);
        for (int f = 5; f >= 2; f--) begin
            tick();
            chk("t2_down_floor", floor_now, f);
        end
        chk("t2_door2", door_open, 1);
        chk("t2_pend_clr", req_pending, 0);
        tick();
        tick();
        chk("t2_busy", busy, 0);
        chk("t2_dir_kept", move_dir, 0);
        cmp_arr("t2_arrive");

        // call at the current floor, then dwell restart
        do_reset();
        call(1);
        exp_q.push_back(1);
        chk("t3_ack", call_ack, 1);
        chk("t3_pend", req_pending, 0);
        chk("t3_door", door_open, 1);
        chk("t3_arrive", arrive, 1);
        tick();
        chk("t3_dwell1", door_open, 1);
        call(1);
        chk("t3_ack2", call_ack, 1);
        chk("t3_pend2", req_pending, 0);
        tick();
        chk("t3_reload", door_open, 1);
        tick();
        chk("t3_closed", door_open, 0);
        chk("t3_busy", busy, 0);
        cmp_arr("t3_arrive");

        // illegal floors and top-floor bound
        call(0);
        chk("t4_ack0", call_ack, 0);
        chk("t4_pend0", req_pending, 0);
        call(9);
        chk("t4_ack9", call_ack, 0);
        chk("t4_pend9", req_pending, 0);
        chk("t4_busy", busy, 0);
        call(8);
        exp_q.push_back(8);
        chk("t4_ack8", call_ack, 1);
        chk("t4_pend8", req_pending, 8'h80);
        for (int f = 2; f <= 8; f++) begin
            tick();
            chk("t4_floor", floor_now, f);
        end
        chk("t4_door", door_open, 1);
        chk("t4_dir_top", move_dir, 0);
        tick();
        tick();
        chk("t4_dir_idle", move_dir, 0);
        chk("t4_idle", busy, 0);
        cmp_arr("t4_arrive");

        // reset mid-MOVE with calls pending
        call(2);
        call(1);
        chk("t5_pend", req_pending, 8'h03);
        for (int f = 7; f >= 4; f--) begin
            tick();
            chk("t5_floor", floor_now, f);
        end
        chk("t5_moving", moving, 1);
        do_reset();
        chk("t5_rst_floor", floor_now, 1);
        chk("t5_rst_pend", req_pending, 0);
        chk("t5_rst_moving", moving, 0);
        chk("t5_rst_door", door_open, 0);
        chk("t5_rst_dir", move_dir, 1);
        chk("t5_rst_busy", busy, 0);
        cmp_arr("t5_arrive");

        // call for the floor being arrived at in the same cycle
        call(3);
        exp_q.push_back(3);
        tick();
        chk("t6_at2", floor_now, 2);
        @(negedge sys_clk);
        step_tick  = 1'b1;
        call_valid = 1'b1;
        call_floor = 4'd3;
        @(negedge sys_clk);
        step_tick  = 1'b0;
        call_valid = 1'b0;
        chk("t6_ack", call_ack, 1);
        chk("t6_pend", req_pending, 0);
        chk("t6_floor", floor_now, 3);
        chk("t6_door", door_open, 1);
        cyc(1);
        tick();
        tick();
        chk("t6_busy", busy, 0);
        chk("t6_pend_end", req_pending, 0);
        cmp_arr("t6_arrive");

        // park at 6
        do_reset();
        call(6);
        exp_q.push_back(6);
        for (int f = 2; f <= 6; f++) tick();
        tick();
        tick();
        chk("t7_parked", floor_now, 6);
        chk("t7_idle", busy, 0);
`ifdef ELEVATOR_HOME_RETURN_EN
        repeat (3) tick();
        chk("t7_pend_early", req_pending, 0);
        tick();
        exp_q.push_back(1);
        chk("t7_home_bit", req_pending, 8'h01);
        chk("t7_home_ack", call_ack, 0);
        for (int i = 0; i < 10 && door_open !== 1'b1; i++) tick();
        chk("t7_home_floor", floor_now, 1);
        chk("t7_home_door", door_open, 1);
        tick();
        tick();
`else
        repeat (20) tick();
        chk("t7_stay_floor", floor_now, 6);
        chk("t7_stay_pend", req_pending, 0);
        chk("t7_stay_moving", moving, 0);
        chk("t7_stay_busy", busy, 0);
`endif
        cmp_arr("t7_arrive");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
